// File: rtl/phase_sequencer_n.sv
// phase_sequencer_n
//   Steps through N_CH one-hot output phases. Each phase stays active for a
//   per-channel dwell count. A clearance interval with every output off
//   follows each phase. The current phase can be held open. In demand mode,
//   channels that are not requesting are skipped. All state changes on the
//   falling edge of CK.
//
// Ports
//   CK     in   clock (falling-edge active)
//   RST    in   synchronous active-high reset, highest priority
//   EN     in   advance enable; low freezes everything except WRAP (forced 0)
//   HOLD   in   extend the current phase while ACTIVE
//   MODE   in   0 = fixed round robin, 1 = demand skip
//   REQ    in   [N_CH]        per-channel service request (MODE=1)
//   DWELL  in   [N_CH*CNT_W]  channel k dwell at DWELL[k*CNT_W +: CNT_W]
//   ACT    out  [N_CH]        one-hot active phase, zero outside ACTIVE
//   PHASE  out  [PH_W]        current / last served channel
//   CNT    out  [CNT_W]       dwell or clearance count
//   CLR    out  clearance in progress
//   WRAP   out  one-cycle pulse on entry to channel 0 from clearance
module phase_sequencer_n #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 8,
    parameter int MIN_DWELL = 2,
    parameter int CLR_CYC   = 2,
    parameter int PH_W      = $clog2(N_CH)
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  HOLD,
    input  logic                  MODE,
    input  logic [N_CH-1:0]       REQ,
    input  logic [N_CH*CNT_W-1:0] DWELL,
    output logic [N_CH-1:0]       ACT,
    output logic [PH_W-1:0]       PHASE,
    output logic [CNT_W-1:0]      CNT,
    output logic                  CLR,
    output logic                  WRAP
);

    localparam logic [CNT_W-1:0] MIN_D    = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);
    localparam logic [N_CH-1:0]  ONE_HOT0 = N_CH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    state_t            r_state;
    logic [N_CH-1:0]   r_act;
    logic [PH_W-1:0]   r_phase;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_clr;
    logic              r_wrap;

    logic [CNT_W-1:0]  w_dwell;
    logic [CNT_W-1:0]  w_eff;
    logic [CNT_W-1:0]  w_last;
    logic              w_dwell_done;
    logic [N_CH-1:0]   w_self;
    logic              w_other_req;
    logic [PH_W-1:0]   w_rr_next;
    logic [PH_W-1:0]   w_dem_next;
    logic              w_dem_found;
    logic [PH_W-1:0]   w_next;

    // Dwell of the channel being served; DWELL is live, not latched.
    always_comb begin
        w_dwell = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_phase == PH_W'(k)) begin
                w_dwell = DWELL[k*CNT_W +: CNT_W];
            end
        end
    end

    // Effective dwell is never below MIN_DWELL (>= 1), so w_last cannot underflow.
    assign w_eff        = (w_dwell < MIN_D) ? MIN_D : w_dwell;
    assign w_last       = w_eff - CNT_W'(1);
    // ">=" rather than "==": a dwell lowered under the running count ends the phase.
    assign w_dwell_done = (r_cnt >= w_last);

    assign w_self      = ONE_HOT0 << r_phase;
    assign w_other_req = |(REQ & ~w_self);

    assign w_rr_next = (r_phase == PH_W'(N_CH - 1)) ? '0 : r_phase + PH_W'(1);

    // Search from the farthest offset down to +1, so the nearest requester
    // after the current channel is the one left standing.
    always_comb begin
        w_dem_next  = '0;
        w_dem_found = 1'b0;
        for (int i = N_CH - 1; i >= 1; i--) begin
            if (REQ[PH_W'((int'(r_phase) + i) % N_CH)]) begin
                w_dem_next  = PH_W'((int'(r_phase) + i) % N_CH);
                w_dem_found = 1'b1;
            end
        end
    end

    assign w_next = (MODE && w_dem_found) ? w_dem_next : w_rr_next;

    always_ff @(negedge CK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_act   <= '0;
            r_phase <= '0;
            r_cnt   <= '0;
            r_clr   <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!EN) begin
            // Freeze, but never stretch a WRAP pulse.
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_ACTIVE;
                    r_phase <= '0;
                    r_cnt   <= '0;
                    r_act   <= ONE_HOT0;
                    r_clr   <= 1'b0;
                end
                S_ACTIVE: begin
                    if (HOLD) begin
                        r_cnt <= r_cnt;
                    end else if (w_dwell_done) begin
                        if (!MODE || w_other_req) begin
                            r_state <= S_CLEAR;
                            r_cnt   <= '0;
                            r_act   <= '0;
                            r_clr   <= 1'b1;
                        end else begin
                            // Nobody else waiting: stay here, count pinned at the terminal value.
                            r_cnt <= w_last;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (r_cnt >= CLR_LAST) begin
                        r_state <= S_ACTIVE;
                        r_phase <= w_next;
                        r_cnt   <= '0;
                        r_act   <= ONE_HOT0 << w_next;
                        r_clr   <= 1'b0;
                        r_wrap  <= (w_next == '0);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_act   <= '0;
                    r_phase <= '0;
                    r_cnt   <= '0;
                    r_clr   <= 1'b0;
                end
            endcase
        end
    end

    assign ACT   = r_act;
    assign PHASE = r_phase;
    assign CNT   = r_cnt;
    assign CLR   = r_clr;
    assign WRAP  = r_wrap;

endmodule

// File: tb/tb_phase_sequencer_n.sv
// tb_phase_sequencer_n
//   Directed bench for phase_sequencer_n (N_CH=4, CNT_W=8, MIN_DWELL=2,
//   CLR_CYC=2). The stimulus drives inputs after each rising edge and
//   queues the output vector expected after the following falling edge.
//   A monitor pops that vector 1 time unit after the falling edge and
//   compares it with the outputs.
module tb_phase_sequencer_n;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;

    logic                  CK = 1'b1;
    logic                  RST;
    logic                  EN;
    logic                  HOLD;
    logic                  MODE;
    logic [N_CH-1:0]       REQ;
    logic [N_CH*CNT_W-1:0] DWELL;
    logic [N_CH-1:0]       ACT;
    logic [1:0]            PHASE;
    logic [CNT_W-1:0]      CNT;
    logic                  CLR;
    logic                  WRAP;

    phase_sequencer_n #(
        .N_CH(N_CH), .CNT_W(CNT_W), .MIN_DWELL(2), .CLR_CYC(2)
    ) dut (
        .CK(CK), .RST(RST), .EN(EN), .HOLD(HOLD), .MODE(MODE), .REQ(REQ),
        .DWELL(DWELL), .ACT(ACT), .PHASE(PHASE), .CNT(CNT), .CLR(CLR),
        .WRAP(WRAP)
    );

    always #5 CK = ~CK;

    typedef struct {
        string      nm;
        logic [3:0] act;
        logic [1:0] ph;
        logic [7:0] cnt;
        logic       clr;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Queue one expected vector, then let the falling edge happen.
    task automatic cyc(input string nm, input logic [3:0] a, input logic [1:0] p,
                       input logic [7:0] c, input logic cl, input logic w);
        exp_t e;
        e.nm = nm; e.act = a; e.ph = p; e.cnt = c; e.clr = cl; e.wrap = w;
        sb.push_back(e);
        @(posedge CK);
    endtask

    task automatic ea(input string nm, input int ch, input int c, input logic w = 1'b0);
        cyc(nm, 4'(1 << ch), 2'(ch), 8'(c), 1'b0, w);
    endtask

    task automatic ec(input string nm, input int ch, input int c);
        cyc(nm, 4'b0000, 2'(ch), 8'(c), 1'b1, 1'b0);
    endtask

    task automatic ei(input string nm);
        cyc(nm, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic set_dw(input int k, input int v);
        DWELL[k*CNT_W +: CNT_W] = 8'(v);
    endtask

    // Monitor: compare each queued expectation just after the falling edge.
    initial begin
        forever begin
            exp_t e;
            @(negedge CK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({ACT, PHASE, CNT, CLR, WRAP} !== {e.act, e.ph, e.cnt, e.clr, e.wrap}) begin
                    bad++;
                    $display("FAIL %s @%0t: got ACT=%b PHASE=%0d CNT=%0d CLR=%b WRAP=%b, want ACT=%b PHASE=%0d CNT=%0d CLR=%b WRAP=%b",
                             e.nm, $time, ACT, PHASE, CNT, CLR, WRAP,
                             e.act, e.ph, e.cnt, e.clr, e.wrap);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; EN = 1'b0; HOLD = 1'b0; MODE = 1'b0; REQ = 4'b0000;
        DWELL = {8'd3, 8'd3, 8'd3, 8'd3};

        // Reset, then round robin: 3 active + 2 clear per channel.
        repeat (3) ei("reset");
        RST = 1'b0; EN = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            for (int c = 0; c < 3; c++) ea("rr_act", ch, c);
            for (int c = 0; c < 2; c++) ec("rr_clr", ch, c);
        end
        ea("rr_wrap", 0, 0, 1'b1);
        ea("rr_after_wrap", 0, 1);

        // Dwell clamp: 0 and 1 both give 2 active cycles.
        set_dw(1, 0); set_dw(2, 1);
        ea("clamp", 0, 2);
        ec("clamp", 0, 0); ec("clamp", 0, 1);
        ea("clamp_dw0", 1, 0); ea("clamp_dw0", 1, 1);
        ec("clamp", 1, 0); ec("clamp", 1, 1);
        ea("clamp_dw1", 2, 0); ea("clamp_dw1", 2, 1);
        ec("clamp", 2, 0); ec("clamp", 2, 1);
        for (int c = 0; c < 3; c++) ea("clamp", 3, c);
        ec("clamp", 3, 0); ec("clamp", 3, 1);
        ea("clamp_wrap", 0, 0, 1'b1);
        set_dw(1, 3); set_dw(2, 3);

        // Hold on channel 0 at CNT=1, then hold ignored during clearance.
        ea("hold", 0, 1);
        HOLD = 1'b1;
        repeat (5) ea("hold_frz", 0, 1);
        HOLD = 1'b0;
        ea("hold_rel", 0, 2);
        ec("hold", 0, 0);
        HOLD = 1'b1;
        ec("hold_clr", 0, 1);
        ea("hold_clr_exit", 1, 0);
        HOLD = 1'b0;

        // Demand skip from channel 0.
        RST = 1'b1;
        ei("rst2");
        RST = 1'b0; MODE = 1'b1; REQ = 4'b0100;
        ea("dem", 0, 0); ea("dem", 0, 1); ea("dem", 0, 2);
        ec("dem", 0, 0); ec("dem", 0, 1);
        ea("dem_skip", 2, 0);
        REQ = 4'b0000;
        ea("dem", 2, 1); ea("dem", 2, 2);
        repeat (10) ea("dem_sat", 2, 2);
        REQ = 4'b0100;
        repeat (2) ea("dem_self_req", 2, 2);
        REQ = 4'b0001;
        ec("dem_go", 2, 0); ec("dem_go", 2, 1);
        ea("dem_wrap", 0, 0, 1'b1);

        // EN freeze: WRAP dropped, then freeze in clearance at CNT=1.
        EN = 1'b0;
        ea("frz_wrap", 0, 0, 1'b0);
        EN = 1'b1; MODE = 1'b0; REQ = 4'b0000;
        ea("frz", 0, 1); ea("frz", 0, 2);
        ec("frz", 0, 0); ec("frz", 0, 1);
        EN = 1'b0;
        repeat (4) ec("frz_clr", 0, 1);
        EN = 1'b1;
        ea("frz_resume", 1, 0);

        // Mid-operation reset on channel 2, CNT=1.
        ea("mrst", 1, 1); ea("mrst", 1, 2);
        ec("mrst", 1, 0); ec("mrst", 1, 1);
        ea("mrst", 2, 0); ea("mrst", 2, 1);
        RST = 1'b1;
        ei("mid_rst");
        RST = 1'b0; EN = 1'b0;
        repeat (2) ei("idle_en0");

        // Lower DWELL_3 from 8 to 3 at CNT=5.
        set_dw(3, 8); EN = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
            for (int c = 0; c < 3; c++) ea("low", ch, c);
            for (int c = 0; c < 2; c++) ec("low", ch, c);
        end
        for (int c = 0; c < 6; c++) ea("low_long", 3, c);
        set_dw(3, 3);
        ec("low_end", 3, 0);
        ec("low_end", 3, 1);
        ea("low_wrap", 0, 0, 1'b1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge CK);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer_n.md
Name: phase_sequencer_n

Overview:
- Parametrised successor to the fixed 14-flop sequential controller benchmark.
- Cycles through N_CH output phases (one-hot).
- Each phase has a per-channel programmable dwell count, followed by a clearance interval with all outputs off.
- Supports hold/extend and a demand-driven skip mode.
- Sits behind the same single-clock fabric as the existing gate-level controllers and drives their phase enables.

Parameters:
- N_CH, 4: number of phases/channels, 2..16.
- CNT_W, 8: dwell/clearance counter width.
- MIN_DWELL, 2: minimum effective dwell in cycles, 1 ≤ MIN_DWELL < 2^CNT_W.
- CLR_CYC, 2: clearance length in cycles, 1 ≤ CLR_CYC < 2^CNT_W.
- PH_W, $clog2(N_CH): phase index width.

Ports:
- CK     input   1            clock; all state updates on falling edge of CK
- RST    input   1            synchronous active-high reset, sampled on falling edge of CK
- EN     input   1            advance enable; 0 freezes all state and outputs
- HOLD   input   1            extend current phase (ACTIVE state only)
- MODE   input   1            0 = fixed round robin; 1 = demand skip
- REQ    input   N_CH         per-channel service request (used in MODE=1)
- DWELL  input   N_CH*CNT_W   channel k dwell = DWELL[k*CNT_W +: CNT_W]
- ACT    output  N_CH         one-hot active phase; all zero outside ACTIVE
- PHASE  output  PH_W         index of current/last served channel
- CNT    output  CNT_W        current dwell or clearance count
- CLR    output  1            1 while in CLEAR state
- WRAP   output  1            one-cycle pulse on entry to channel 0 from CLEAR

Behaviour:
- All outputs are registered.
- States: IDLE, ACTIVE, CLEAR.
- Reset:
  - RST=1 at an edge forces IDLE, ACT=0, PHASE=0, CNT=0, CLR=0, WRAP=0.
  - RST has priority over EN and over everything else.
  - Mid-operation reset takes effect on that same edge; no partial phase completes.
- EN=0: state, CNT, PHASE, ACT and CLR hold their values. WRAP is forced to 0, so a pulse is never stretched.
- Effective dwell: eff(k) = max(DWELL_k, MIN_DWELL). DWELL_k=0 therefore yields MIN_DWELL.
- IDLE:
  - EN=1 → ACTIVE, PHASE=0, CNT=0, ACT=1<<0.
  - Latency is one edge from EN sampled high to ACT valid.
  - No WRAP pulse on this entry.
- ACTIVE (channel p):
  - Each enabled edge with CNT < eff(p)-1: CNT+1.
  - HOLD=1 freezes CNT at its current value; the phase is extended indefinitely.
  - At CNT == eff(p)-1 with HOLD=0, the phase ends if either:
    - MODE=0, or
    - MODE=1 and there exists q≠p with REQ[q]=1.
    - On phase end: → CLEAR, CNT=0, ACT=0, CLR=1.
  - MODE=1 with no other requester: remain in ACTIVE; CNT saturates at eff(p)-1 (never wraps).
- CLEAR:
  - HOLD is ignored.
  - CNT increments each enabled edge.
  - At CNT == CLR_CYC-1: → ACTIVE on channel n, CNT=0, CLR=0, ACT=1<<n, PHASE=n.
  - Choice of n:
    - MODE=0: n = (p+1) mod N_CH.
    - MODE=1: n = first q in order p+1, p+2, … (mod N_CH), q≠p, with REQ[q]=1, evaluated on the exit edge.
    - MODE=1 and no request is present at exit: n = (p+1) mod N_CH.
  - WRAP=1 for exactly one cycle when n==0.
- REQ and MODE are sampled only at the decision edges above. Changes elsewhere have no effect. MODE switching mid-phase is legal.
- DWELL is sampled continuously:
  - Raising DWELL_p mid-phase extends the phase.
  - Lowering DWELL_p below the current CNT+1 ends the phase at the next enabled edge (CNT ≥ eff-1 is treated as the terminal condition).
- Invariants:
  - ACT is one-hot or zero.
  - ACT≠0 only in ACTIVE.
  - CLR and ACT are never both nonzero.

Test Plan:
- Reset and round robin (N_CH=4, MIN_DWELL=2, CLR_CYC=2, all DWELL=3, MODE=0):
  - Stimulus: RST=1 for 3 edges, then EN=1.
  - Response: ACT = 0001 (3 cycles), 0000/CLR=1 (2 cycles), 0010, 0100, 1000, then 0001 with WRAP=1 for 1 cycle.
  - Cycle period is 20 edges.
- Dwell clamp: DWELL_1=0 (channel 1) → ACT=0010 for exactly 2 cycles; DWELL_2=1 → 2 cycles.
- Hold on channel 0 (DWELL=3): HOLD=1 for 5 edges while CNT=1 → CNT stays 1, ACT=0001 for 8 cycles total. HOLD during CLEAR → clearance still 2 cycles.
- Demand skip (MODE=1, on channel 0):
  - REQ=0100 → after dwell, CLEAR 2 cycles, then ACT=0100 (channel 1 skipped).
  - Then REQ=0000 → ACT=0100 persists and CNT saturates at 2 for 10+ cycles.
  - Then REQ=0001 → CLEAR, then 0001 with WRAP=1.
- EN freeze and mid-operation reset:
  - EN=0 for 4 edges at CLEAR CNT=1 → CNT, CLR, PHASE unchanged, WRAP=0; resume finishes clearance in 1 edge.
  - RST=1 during ACTIVE channel 2 with CNT=1 → next edge IDLE, ACT=0000, CNT=0, PHASE=0.
- Lower DWELL mid-phase: channel 3 at CNT=5 with DWELL_3=8, drop DWELL_3 to 3 → next enabled edge enters CLEAR, ACT=0000.
